// File: rtl/bus_arb_2m1s.sv
// Two-master / one-slave bus arbiter: round-robin on contention, lock until
// acceptance, single outstanding read with timeout-forced completion.
module bus_arb_2m1s #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk_i,
   input  logic        arst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_ack_o,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_ack_o,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_o,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_ack_i,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_i,
   output logic        busy_o,
   output logic        timeout_o
);

   // state     | meaning
   // ST_IDLE   | arbitrate between requesters, forward winner
   // ST_HOLD   | slave stalled; bus locked to grant_r until accepted or dropped
   // ST_WAIT   | read accepted; waiting for response of owner_r
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   logic [1:0]  state_r;
   logic        prio_r;
   logic        grant_r;
   logic        owner_r;
   logic [15:0] cnt_r;

   logic        sel;
   logic        sel_vld;
   logic        sel_we;
   logic        accept;
   logic        in_wait;
   logic        real_resp;
   logic        tmo;
   logic        done;
   logic [31:0] rdata;

   always_comb begin
      sel     = 1'b0;
      sel_vld = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (m0_req_i && m1_req_i) begin
               sel     = prio_r;
               sel_vld = 1'b1;
            end else if (m0_req_i) begin
               sel     = 1'b0;
               sel_vld = 1'b1;
            end else if (m1_req_i) begin
               sel     = 1'b1;
               sel_vld = 1'b1;
            end
         end
         ST_HOLD: begin
            sel     = grant_r;
            sel_vld = grant_r ? m1_req_i : m0_req_i;
         end
         default: begin
            sel     = 1'b0;
            sel_vld = 1'b0;
         end
      endcase
   end

   assign sel_we = sel ? m1_we_i : m0_we_i;
   // Handshakes are gated while reset is held so nothing is accepted then.
   assign accept = sel_vld & s_ack_i & ~arst_i;

   assign s_req_o   = sel_vld & ~arst_i;
   assign s_we_o    = sel_vld & sel_we;
   assign s_addr_o  = sel_vld ? (sel ? m1_addr_i  : m0_addr_i)  : 32'h0;
   assign s_be_o    = sel_vld ? (sel ? m1_be_i    : m0_be_i)    : 4'h0;
   assign s_wdata_o = sel_vld ? (sel ? m1_wdata_i : m0_wdata_i) : 32'h0;

   assign m0_ack_o = accept & ~sel;
   assign m1_ack_o = accept & sel;

   assign in_wait   = (state_r == ST_WAIT);
   assign real_resp = in_wait & s_resp_i;
   assign tmo       = in_wait & ~s_resp_i & (cnt_r == TIMEOUT_C);
   assign done      = real_resp | tmo;
   assign rdata     = real_resp ? s_rdata_i : ERR_DATA;

   assign m0_resp_o  = done & ~owner_r;
   assign m1_resp_o  = done & owner_r;
   assign m0_rdata_o = m0_resp_o ? rdata : 32'h0;
   assign m1_rdata_o = m1_resp_o ? rdata : 32'h0;
   assign timeout_o  = tmo;
   assign busy_o     = (state_r != ST_IDLE);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_r <= ST_IDLE;
         prio_r  <= 1'b0;
         grant_r <= 1'b0;
         owner_r <= 1'b0;
         cnt_r   <= 16'h0;
      end else begin
         case (state_r)
            ST_IDLE, ST_HOLD: begin
               if (accept) begin
                  prio_r <= ~sel;
                  if (sel_we) begin
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_WAIT;
                     owner_r <= sel;
                     cnt_r   <= 16'h0;
                  end
               end else if (sel_vld) begin
                  state_r <= ST_HOLD;
                  grant_r <= sel;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (done) begin
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 16'h1;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arb_2m1s.sv
// Bench for bus_arb_2m1s: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_bus_arb_2m1s;

   localparam int TMO = 4;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        mreq [2];
   logic        mwe  [2];
   logic [31:0] maddr [2];
   logic [3:0]  mbe  [2];
   logic [31:0] mwdata [2];
   logic        ack0, ack1, resp0, resp1;
   logic [31:0] rdata0, rdata1;
   logic        s_req, s_we, s_ack, s_resp;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_be;
   logic        busy, tmo_o;

   int checks = 0;
   int failures = 0;

   // model: bus lock holder, outstanding read owner, wait count, preferred master
   int lock_m = -1;
   int rd_owner = -1;
   int wait_n = 0;
   int pref = 0;
   logic [1:0] e_ack;

   always #5 clk = ~clk;

   bus_arb_2m1s #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .clk_i(clk), .arst_i(arst),
      .m0_req_i(mreq[0]), .m0_we_i(mwe[0]), .m0_addr_i(maddr[0]), .m0_be_i(mbe[0]),
      .m0_wdata_i(mwdata[0]), .m0_ack_o(ack0), .m0_resp_o(resp0), .m0_rdata_o(rdata0),
      .m1_req_i(mreq[1]), .m1_we_i(mwe[1]), .m1_addr_i(maddr[1]), .m1_be_i(mbe[1]),
      .m1_wdata_i(mwdata[1]), .m1_ack_o(ack1), .m1_resp_o(resp1), .m1_rdata_o(rdata1),
      .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
      .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
      .busy_o(busy), .timeout_o(tmo_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic issue(input int k, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      mreq[k] = 1'b1; mwe[k] = we; maddr[k] = addr; mbe[k] = be; mwdata[k] = wd;
   endtask

   // Evaluate one clock cycle: inputs were set at the preceding negedge.
   task automatic cycle();
      logic [1:0]  e_resp;
      logic [31:0] e_rd [2];
      logic        e_sreq, e_we, e_busy, e_tmo;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      int cand, n_lock, n_owner, n_wait, n_pref;
      #1;
      e_ack = 2'b00; e_resp = 2'b00; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
      e_sreq = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
      e_tmo = 1'b0;
      e_busy = (lock_m >= 0) || (rd_owner >= 0);
      n_lock = lock_m; n_owner = rd_owner; n_wait = wait_n; n_pref = pref;
      if (rd_owner >= 0) begin
         if (s_resp) begin
            e_resp[rd_owner] = 1'b1; e_rd[rd_owner] = s_rdata; n_owner = -1;
         end else if (wait_n == TMO) begin
            e_resp[rd_owner] = 1'b1; e_rd[rd_owner] = ERR; e_tmo = 1'b1; n_owner = -1;
         end else begin
            n_wait = wait_n + 1;
         end
      end else begin
         cand = -1;
         if (lock_m >= 0) begin
            if (mreq[lock_m]) cand = lock_m;
            else n_lock = -1;
         end else if (mreq[0] && mreq[1]) cand = pref;
         else if (mreq[0]) cand = 0;
         else if (mreq[1]) cand = 1;
         if (cand >= 0) begin
            e_sreq = 1'b1; e_we = mwe[cand]; e_addr = maddr[cand];
            e_be = mbe[cand]; e_wdata = mwdata[cand];
            if (s_ack) begin
               e_ack[cand] = 1'b1; n_pref = 1 - cand; n_lock = -1;
               if (!mwe[cand]) begin n_owner = cand; n_wait = 0; end
            end else begin
               n_lock = cand;
            end
         end
      end
      chk("m0_ack", 32'(ack0), 32'(e_ack[0]));
      chk("m1_ack", 32'(ack1), 32'(e_ack[1]));
      chk("m0_resp", 32'(resp0), 32'(e_resp[0]));
      chk("m1_resp", 32'(resp1), 32'(e_resp[1]));
      chk("m0_rdata", rdata0, e_rd[0]);
      chk("m1_rdata", rdata1, e_rd[1]);
      chk("s_req", 32'(s_req), 32'(e_sreq));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("timeout", 32'(tmo_o), 32'(e_tmo));
      if (e_sreq) begin
         chk("s_we", 32'(s_we), 32'(e_we));
         chk("s_addr", s_addr, e_addr);
         chk("s_be", 32'(s_be), 32'(e_be));
         chk("s_wdata", s_wdata, e_wdata);
      end
      lock_m = n_lock; rd_owner = n_owner; wait_n = n_wait; pref = n_pref;
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (e_ack[k]) mreq[k] = 1'b0;
   endtask

   task automatic model_reset();
      lock_m = -1; rd_owner = -1; wait_n = 0; pref = 0;
      mreq[0] = 1'b0; mreq[1] = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_sreq"}, 32'(s_req), 32'h0);
      chk({tag, "_acks"}, 32'({ack1, ack0}), 32'h0);
      chk({tag, "_resps"}, 32'({resp1, resp0}), 32'h0);
      chk({tag, "_tmo"}, 32'(tmo_o), 32'h0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         mreq[k] = 0; mwe[k] = 0; maddr[k] = 0; mbe[k] = 0; mwdata[k] = 0;
      end
      s_ack = 0; s_resp = 0; s_rdata = 0;
      @(negedge clk); @(negedge clk);
      #1 check_reset_outputs("rst");
      chk("rst_rdata", rdata0 | rdata1, 32'h0);
      @(negedge clk); arst = 1'b0;

      // both masters read at once after reset: m0 first, m1 after m0's response
      issue(0, 0, 32'h100, 4'hF, 0); issue(1, 0, 32'h104, 4'hF, 0); s_ack = 1;
      cycle(); cycle();
      s_resp = 1; s_rdata = 32'hA5A5_0001; cycle(); s_resp = 0;
      cycle();
      s_resp = 1; s_rdata = 32'hA5A5_0002; cycle(); s_resp = 0;

      // slave stalls m0 write at 0x10 for 3 cycles; m1 requests meanwhile
      s_ack = 0; issue(0, 1, 32'h10, 4'h3, 32'h1111_2222);
      cycle();
      issue(1, 1, 32'h20, 4'hF, 32'h3333_4444);
      cycle(); cycle();
      s_ack = 1; cycle(); cycle();

      // m1 read answered after 5 cycles
      issue(1, 0, 32'h40, 4'hF, 0); cycle(); s_ack = 0;
      repeat (4) cycle();
      s_resp = 1; s_rdata = 32'h1234_5678; cycle(); s_resp = 0;

      // m0 read never answered: forced completion, then a late response
      s_ack = 1; issue(0, 0, 32'h50, 4'hF, 0); cycle(); s_ack = 0;
      repeat (6) cycle();
      s_resp = 1; s_rdata = 32'h0BAD_0BAD; cycle(); s_resp = 0;

      // reset in the middle of an outstanding read
      s_ack = 1; issue(1, 0, 32'h60, 4'hF, 0); cycle(); s_ack = 0;
      cycle();
      #2 arst = 1'b1;
      #1 check_reset_outputs("midrst");
      model_reset();
      @(negedge clk); @(negedge clk); arst = 1'b0;
      s_resp = 1; s_rdata = 32'h7777_7777; cycle(); s_resp = 0;
      issue(0, 1, 32'h70, 4'hF, 1); issue(1, 1, 32'h74, 4'hF, 2); s_ack = 1;
      cycle(); cycle();

      // m1 back-to-back writes
      for (int i = 0; i < 5; i++) begin
         issue(1, 1, 32'h200 + 32'(i * 4), 4'hF, $urandom); cycle();
      end

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (!mreq[k] && ($urandom % 3 == 0))
               issue(k, 1'($urandom % 2), $urandom, 4'($urandom), $urandom);
            else if (mreq[k] && ($urandom % 20 == 0))
               mreq[k] = 1'b0;
         end
         s_ack = ($urandom % 3 != 0);
         s_resp = ($urandom % 4 == 0);
         s_rdata = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
